// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit driving a req/gnt/rvalid data-memory bus
module riscv_lsu #(
  parameter int XLEN      = 32,
  parameter int P_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_we,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_busy,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_lsu_fault,
  output logic [1:0]      o_lsu_cause,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  localparam int CW = $clog2(P_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  logic            req_n, done_n, fault_n;
  logic [1:0]      cause_n;
  logic [XLEN-1:0] rdata_n;

  logic            legal, misal;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in, shifted, load_ext;

  // Decode of the incoming request; only meaningful in IDLE.
  always_comb begin
    legal = 1'b0;
    case (i_lsu_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !i_lsu_we;
      default:                legal = 1'b0;
    endcase
    misal = ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
            ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
    be_in    = 4'b1111;
    wdata_in = i_lsu_wdata;
    case (i_lsu_funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << i_lsu_addr[1:0];
        wdata_in = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << i_lsu_addr[1:0];
        wdata_in = {2{i_lsu_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!i_lsu_we) wdata_in = '0;
  end

  assign shifted = i_dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    req_n   = 1'b0;
    done_n  = 1'b0;
    fault_n = 1'b0;
    cause_n = 2'b00;
    rdata_n = '0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (i_lsu_valid) begin
          if (!legal) begin
            state_n = S_DONE; done_n = 1'b1; fault_n = 1'b1; cause_n = 2'b10;
          end else if (misal) begin
            state_n = S_DONE; done_n = 1'b1; fault_n = 1'b1; cause_n = 2'b01;
          end else begin
            state_n = S_REQ; req_n = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (i_dmem_gnt) begin
          done_n  = we_q;
          state_n = we_q ? S_DONE : S_RESP;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = S_DONE; done_n = 1'b1; fault_n = 1'b1; cause_n = 2'b11;
        end else begin
          req_n = 1'b1;
        end
      end
      S_RESP: begin
        // A response arriving on the final allowed cycle still counts.
        if (i_dmem_rvalid) begin
          state_n = S_DONE; done_n = 1'b1; rdata_n = load_ext;
        end else if (cnt == CNT_LAST) begin
          state_n = S_DONE; done_n = 1'b1; fault_n = 1'b1; cause_n = 2'b11;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      o_lsu_busy   <= 1'b0;
      o_lsu_done   <= 1'b0;
      o_lsu_fault  <= 1'b0;
      o_lsu_cause  <= 2'b00;
      o_lsu_rdata  <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= 4'b0000;
      o_dmem_wdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      o_lsu_busy  <= (state_n != S_IDLE);
      o_lsu_done  <= done_n;
      o_lsu_fault <= fault_n;
      o_lsu_cause <= cause_n;
      o_lsu_rdata <= rdata_n;
      o_dmem_req  <= req_n;
      if (state == S_IDLE && i_lsu_valid) begin
        we_q         <= i_lsu_we;
        f3_q         <= i_lsu_funct3;
        off_q        <= i_lsu_addr[1:0];
        o_dmem_we    <= i_lsu_we;
        o_dmem_addr  <= {i_lsu_addr[XLEN-1:2], 2'b00};
        o_dmem_be    <= be_in;
        o_dmem_wdata <= wdata_in;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized self-checking bench for riscv_lsu with a transaction-level model
module tb_riscv_lsu;
  localparam int P_TIMEOUT = 16;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_lsu_valid = 1'b0, i_lsu_we = 1'b0;
  logic [2:0]  i_lsu_funct3 = 3'b000;
  logic [31:0] i_lsu_addr = '0, i_lsu_wdata = '0;
  logic        o_lsu_busy, o_lsu_done, o_lsu_fault, o_dmem_req, o_dmem_we;
  logic [31:0] o_lsu_rdata, o_dmem_addr, o_dmem_wdata;
  logic [1:0]  o_lsu_cause;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt = 1'b0, i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;

  riscv_lsu #(.XLEN(32), .P_TIMEOUT(P_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_lsu_valid(i_lsu_valid), .i_lsu_we(i_lsu_we), .i_lsu_funct3(i_lsu_funct3),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
    .o_lsu_busy(o_lsu_busy), .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_fault(o_lsu_fault), .o_lsu_cause(o_lsu_cause),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0, cyc = 0, v_cyc = 0, done_cyc = 0;
  bit chk_en = 0, req_seen = 0;
  logic        exp_busy = 0, exp_req = 0, exp_done = 0, exp_fault = 0, exp_we = 0;
  logic [1:0]  exp_cause = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] exp_rdata = 0, exp_addr = 0, exp_wd = 0;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wd, last_rdata;
  logic        last_fault;
  logic [1:0]  last_cause;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expectation the driver publishes.
  always @(negedge i_clk) begin
    if (o_dmem_req) begin
      req_seen = 1; last_be = o_dmem_be; last_addr = o_dmem_addr; last_wd = o_dmem_wdata;
    end
    if (o_lsu_done) begin
      done_cyc = cyc; last_rdata = o_lsu_rdata; last_fault = o_lsu_fault; last_cause = o_lsu_cause;
    end
    if (chk_en && !i_rst) begin
      chk("busy", 32'(o_lsu_busy), 32'(exp_busy));
      chk("req", 32'(o_dmem_req), 32'(exp_req));
      chk("done", 32'(o_lsu_done), 32'(exp_done));
      if (exp_req) begin
        chk("dmem_addr", o_dmem_addr, exp_addr);
        chk("dmem_be", 32'(o_dmem_be), 32'(exp_be));
        chk("dmem_wdata", o_dmem_wdata, exp_wd);
        chk("dmem_we", 32'(o_dmem_we), 32'(exp_we));
      end
      if (exp_done) begin
        chk("fault", 32'(o_lsu_fault), 32'(exp_fault));
        chk("cause", 32'(o_lsu_cause), 32'(exp_cause));
        chk("rdata", o_lsu_rdata, exp_rdata);
      end
    end
  end

  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int m_cause(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3[2])) return 2;
    if (a % m_size(f3) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << m_size(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v, lim;
    if (m_size(f3) == 4) return rd;
    lim = (m_size(f3) == 1) ? 256 : 65536;
    v = longint'((rd >> (8 * (a % 4)))) % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic junk();
    i_lsu_valid = 1'($urandom); i_lsu_we = 1'($urandom); i_lsu_funct3 = 3'($urandom);
    i_lsu_addr = $urandom; i_lsu_wdata = $urandom;
  endtask

  task automatic idle_exp();
    exp_busy = 0; exp_req = 0; exp_done = 0;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd_in, input int gdly, input int rdly, input logic [31:0] rd);
    int cause;
    bit ok;
    cause = m_cause(we, f3, addr);
    idle_exp();
    i_lsu_valid = 1; i_lsu_we = we; i_lsu_funct3 = f3; i_lsu_addr = addr; i_lsu_wdata = wd_in;
    i_dmem_gnt = 0; i_dmem_rvalid = 0;
    req_seen = 0; v_cyc = cyc;
    step(); junk();
    if (cause == 0) begin
      ok = 0;
      for (int n = 0; n < P_TIMEOUT; n++) begin
        exp_busy = 1; exp_req = 1; exp_done = 0; exp_we = we;
        exp_addr = addr & ~32'h3; exp_be = m_be(f3, addr);
        exp_wd = we ? m_wdata(f3, wd_in) : 32'h0;
        i_dmem_gnt = (n == gdly); i_dmem_rvalid = 1'($urandom); i_dmem_rdata = $urandom;
        step(); junk();
        if (n == gdly) begin ok = 1; break; end
      end
      i_dmem_gnt = 0; i_dmem_rvalid = 0;
      if (!ok) cause = 3;
      else if (!we) begin
        ok = 0;
        for (int n = 0; n < P_TIMEOUT; n++) begin
          exp_busy = 1; exp_req = 0; exp_done = 0;
          i_dmem_rvalid = (n == rdly); i_dmem_rdata = (n == rdly) ? rd : $urandom;
          i_dmem_gnt = 1'($urandom);
          step(); junk();
          if (n == rdly) begin ok = 1; break; end
        end
        i_dmem_rvalid = 0; i_dmem_gnt = 0;
        if (!ok) cause = 3;
      end
    end
    exp_busy = 1; exp_req = 0; exp_done = 1; exp_fault = (cause != 0); exp_cause = 2'(cause);
    exp_rdata = (!we && cause == 0) ? m_load(f3, addr, rd) : 32'h0;
    step();
    i_lsu_valid = 0; idle_exp();
    i_dmem_rvalid = 1'($urandom); i_dmem_gnt = 1'($urandom); i_dmem_rdata = $urandom;
    step();
    i_dmem_rvalid = 0; i_dmem_gnt = 0;
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return r;
    if (r == 6) return P_TIMEOUT - 2;
    if (r == 7) return P_TIMEOUT - 1;
    if (r == 8) return P_TIMEOUT;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_lsu_busy), 0);
    chk({tag, "_done"}, 32'(o_lsu_done), 0);
    chk({tag, "_fault"}, 32'(o_lsu_fault), 0);
    chk({tag, "_cause"}, 32'(o_lsu_cause), 0);
    chk({tag, "_rdata"}, o_lsu_rdata, 0);
    chk({tag, "_req"}, 32'(o_dmem_req), 0);
    chk({tag, "_we"}, 32'(o_dmem_we), 0);
    chk({tag, "_addr"}, o_dmem_addr, 0);
    chk({tag, "_be"}, 32'(o_dmem_be), 0);
    chk({tag, "_wdata"}, o_dmem_wdata, 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1 chk_all_zero("reset");
    i_rst = 0; chk_en = 1;
    step();

    txn(1'b1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wdata", last_wd, 32'hA5A5A5A5);
    chk("sb_addr", last_addr, 32'h1000);
    chk("sb_latency", 32'(done_cyc - v_cyc + 1), 3);
    chk("sb_fault", 32'(last_fault), 0);

    txn(1'b0, 3'b000, 32'h2001, 0, 0, 0, 32'h0000F000);
    chk("lb_rdata", last_rdata, 32'hFFFFFFF0);
    chk("lb_latency", 32'(done_cyc - v_cyc + 1), 4);
    txn(1'b0, 3'b100, 32'h2001, 0, 0, 0, 32'h0000F000);
    chk("lbu_rdata", last_rdata, 32'h000000F0);

    txn(1'b0, 3'b010, 32'h3002, 0, 0, 0, 0);
    chk("lw_mis_noreq", 32'(req_seen), 0);
    chk("lw_mis_latency", 32'(done_cyc - v_cyc + 1), 2);
    chk("lw_mis_cause", 32'(last_cause), 1);
    txn(1'b1, 3'b100, 32'h3001, 0, 0, 0, 0);
    chk("sbu_illegal_cause", 32'(last_cause), 2);
    chk("sbu_illegal_noreq", 32'(req_seen), 0);

    txn(1'b0, 3'b001, 32'h4000, 0, 1000, 0, 0);
    chk("lh_timeout_cause", 32'(last_cause), 3);
    chk("lh_timeout_latency", 32'(done_cyc - v_cyc + 1), P_TIMEOUT + 2);
    i_dmem_rvalid = 1; i_dmem_rdata = 32'hDEADBEEF;
    repeat (3) step();
    i_dmem_rvalid = 0;

    txn(1'b0, 3'b101, 32'h5002, 0, 3, 0, 32'h80011234);
    chk("lhu_rdata", last_rdata, 32'h00008001);
    chk("lhu_latency", 32'(done_cyc - v_cyc + 1), 7);

    txn(1'b0, 3'b010, 32'h7000, 0, P_TIMEOUT - 1, P_TIMEOUT - 1, 32'h12345678);
    chk("edge_event_wins", last_rdata, 32'h12345678);

    // Asynchronous reset while waiting for read data.
    i_lsu_valid = 1; i_lsu_we = 0; i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h8000;
    step(); i_lsu_valid = 0; chk_en = 0;
    i_dmem_gnt = 1; step(); i_dmem_gnt = 0;
    #2 i_rst = 1;
    #1 chk_all_zero("async_rst");
    step(); i_rst = 0; idle_exp(); chk_en = 1;
    step();
    txn(1'b1, 3'b010, 32'h6000, 32'hCAFEF00D, 1, 0, 0);
    chk("sw_after_rst_fault", 32'(last_fault), 0);
    chk("sw_after_rst_wdata", last_wd, 32'hCAFEF00D);

    for (int t = 0; t < 80; t++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      txn(1'($urandom), f3, $urandom, $urandom, pick_dly(), pick_dly(), $urandom);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
